// File: rtl/redstone_latch_bank.sv
// Bank of WIDTH lockable redstone repeaters clocked by the redstone tick.
// Each channel has its own delay and pulse-extension counter. All channels share one lock line and one clear line.
module redstone_latch_bank #(
    parameter int   WIDTH      = 8,
    parameter int   DELAY      = 1,
    parameter int   LOCK_DELAY = 1,
    parameter logic INVERT     = 1'b0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_in,
    input  logic             i_lock,
    input  logic             i_clear,
    output logic [WIDTH-1:0] o_q,
    output logic [WIDTH-1:0] o_busy,
    output logic             o_locked
);

    localparam logic [2:0] C_DELAY = 3'(DELAY);

    generate
        if (DELAY < 1 || DELAY > 4) begin : g_bad_delay
            $error("redstone_latch_bank: DELAY must be 1..4");
        end
        if (LOCK_DELAY < 0 || LOCK_DELAY > 4) begin : g_bad_lock_delay
            $error("redstone_latch_bank: LOCK_DELAY must be 0..4");
        end
        if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
            $error("redstone_latch_bank: WIDTH must be 1..64");
        end
    endgenerate

    logic             w_lock_eff;
    logic [WIDTH-1:0] w_st;
    logic [WIDTH-1:0] w_busy;

    // With LOCK_DELAY == 0, i_lock drives the lock directly.
    // The combinational path from i_lock to o_locked exists only in this case.
    generate
        if (LOCK_DELAY == 0) begin : g_lock_direct
            assign w_lock_eff = i_lock;
        end else begin : g_lock_pipe
            logic [LOCK_DELAY-1:0] r_lock_pipe;

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_lock_pipe <= '0;
                end else begin
                    r_lock_pipe[0] <= i_lock;
                    for (int k = 1; k < LOCK_DELAY; k++) begin
                        r_lock_pipe[k] <= r_lock_pipe[k-1];
                    end
                end
            end

            assign w_lock_eff = r_lock_pipe[LOCK_DELAY-1];
        end
    endgenerate

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_chan
            logic       r_st;
            logic       r_tgt;
            logic [2:0] r_cnt;

            // Priority order is clear, then lock, then the repeater transition.
            // While the counter runs, the input is ignored, which stretches short pulses to DELAY ticks.
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_st  <= 1'b0;
                    r_tgt <= 1'b0;
                    r_cnt <= 3'd0;
                end else if (i_clear) begin
                    r_st  <= 1'b0;
                    r_cnt <= 3'd0;
                end else if (w_lock_eff) begin
                    r_cnt <= 3'd0;
                end else if (r_cnt == 3'd0) begin
                    if (i_in[gi] != r_st) begin
                        r_tgt <= i_in[gi];
                        r_cnt <= C_DELAY;
                    end
                end else if (r_cnt > 3'd1) begin
                    r_cnt <= r_cnt - 3'd1;
                end else begin
                    r_st <= r_tgt;
                    if (i_in[gi] != r_tgt) begin
                        r_tgt <= i_in[gi];
                        r_cnt <= C_DELAY;
                    end else begin
                        r_cnt <= 3'd0;
                    end
                end
            end

            assign w_st[gi]   = r_st;
            assign w_busy[gi] = (r_cnt != 3'd0);
        end
    endgenerate

    assign o_q      = w_st ^ {WIDTH{INVERT}};
    assign o_busy   = w_busy;
    assign o_locked = w_lock_eff;

endmodule
